// File: rtl/instr_encoder.sv
// Mnemonic-to-machine-word encoder feeding instruction memory.
// Each accepted request is encoded, then written at an auto-incrementing address.
module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              addr_load,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              full,
    output logic              err,
    output logic [ADDR_W:0]   wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_RST  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_t      state, state_d;
    logic [4:0]  l_mnem, l_rs, l_rt, l_rd;
    logic [15:0] l_imm;
    logic [25:0] l_target;
    logic [31:0] enc;
    logic        legal;
    logic [4:0]  iop;
    logic        hs;

    assign in_ready = !rst && (state == IDLE) && !full && !addr_load;
    assign hs       = in_valid && in_ready;
    assign imem_we  = (state == WR);
    assign err      = (state == ENC) && !legal;

    // I-type ALU ops 9..16 map onto opcodes 010000..010111 in order
    assign iop = l_mnem - 5'd9;

    always_comb begin
        enc   = '0;
        legal = 1'b1;
        if (l_mnem <= 5'd7) begin
            enc = {6'b000000, l_rs, l_rt, l_rd, 5'b0, 3'b000, l_mnem[2:0]};
        end else if (l_mnem == 5'd8) begin
            enc = {6'b000000, l_rs, 15'b0, 6'b001000};
        end else if (l_mnem <= 5'd16) begin
            enc = {3'b010, iop[2:0], l_rs, l_rt, l_imm};
        end else if (l_mnem == 5'd17) begin
            enc = {6'b100011, l_rs, l_rt, l_imm};
        end else if (l_mnem == 5'd18) begin
            enc = {6'b101011, l_rs, l_rt, l_imm};
        end else if (l_mnem == 5'd19) begin
            enc = {6'b110000, l_rs, l_rt, l_imm};
        end else if (l_mnem == 5'd20) begin
            enc = {6'b110001, l_target};
        end else if (l_mnem == 5'd21) begin
            enc = {6'b110011, l_target};
        end else begin
            legal = 1'b0;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs) state_d = ENC;
            ENC:     state_d = legal ? WR : IDLE;
            WR:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            imem_addr  <= ADDR_RST;
            imem_wdata <= '0;
            full       <= 1'b0;
            wr_count   <= '0;
            l_mnem     <= '0;
            l_rs       <= '0;
            l_rt       <= '0;
            l_rd       <= '0;
            l_imm      <= '0;
            l_target   <= '0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (addr_load) begin
                        imem_addr <= addr_in;
                        full      <= 1'b0;
                        wr_count  <= '0;
                    end else if (hs) begin
                        l_mnem   <= mnem;
                        l_rs     <= rs;
                        l_rt     <= rt;
                        l_rd     <= rd;
                        l_imm    <= imm;
                        l_target <= target;
                    end
                end
                ENC: begin
                    if (legal) imem_wdata <= enc;
                end
                WR: begin
                    // the top address is written once, then the block stalls
                    if (imem_addr == ADDR_LAST) full <= 1'b1;
                    else imem_addr <= imem_addr + 1'b1;
                    wr_count <= wr_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected writes queued at issue,
// popped and checked by an independent monitor on every imem strobe.
module tb_instr_encoder;

    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  mnem, rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic        addr_load;
    logic [7:0]  addr_in;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        full;
    logic        err;
    logic [8:0]  wr_count;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .mnem(mnem), .rs(rs), .rt(rt), .rd(rd),
        .imm(imm), .target(target),
        .addr_load(addr_load), .addr_in(addr_in),
        .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .full(full),
        .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;

    logic [7:0] m_addr;
    logic [8:0] m_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (imem_we) begin
            exp_t e;
            if (sb.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_write: addr %h data %h",
                         imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(imem_addr), 64'(e.a));
                chk("wr_data", 64'(imem_wdata), 64'(e.d));
                chk("wr_cycle", 64'(cyc), 64'(e.c));
            end
        end
    end

    task automatic issue(input logic [4:0] m, input logic [4:0] s,
                         input logic [4:0] t, input logic [4:0] d,
                         input logic [15:0] im, input logic [25:0] tg,
                         input logic [31:0] exp, input bit legal);
        int n = 0;
        @(negedge clk);
        mnem = m; rs = s; rt = t; rd = d; imm = im; target = tg;
        in_valid = 1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 0;
            return;
        end
        if (legal) begin
            sb.push_back('{a: m_addr, d: exp, c: cyc + 2});
            if (m_addr != 8'hFF) m_addr = m_addr + 1;
            m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("err_in_enc", 64'(err), 64'(!legal));
        if (!legal) begin
            chk("err_addr_hold", 64'(imem_addr), 64'(m_addr));
            chk("err_cnt_hold", 64'(wr_count), 64'(m_cnt));
            @(negedge clk);
            chk("err_ready_back", 64'(in_ready), 64'd1);
            chk("err_gone", 64'(err), 64'd0);
        end else begin
            @(negedge clk);
            @(negedge clk);
            chk("post_addr", 64'(imem_addr), 64'(m_addr));
            chk("post_cnt", 64'(wr_count), 64'(m_cnt));
        end
    endtask

    task automatic load(input logic [7:0] a);
        @(negedge clk);
        addr_load = 1;
        addr_in = a;
        in_valid = 1;
        #1 chk("ready_low_on_load", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        addr_load = 0;
        in_valid = 0;
        m_addr = a;
        m_cnt = 0;
        @(negedge clk);
        chk("load_addr", 64'(imem_addr), 64'(a));
        chk("load_full", 64'(full), 64'd0);
        chk("load_cnt", 64'(wr_count), 64'd0);
        chk("load_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int n;
        rst = 1; in_valid = 1; addr_load = 0; addr_in = 0;
        mnem = 0; rs = 0; rt = 0; rd = 0; imm = 0; target = 0;
        m_addr = 0; m_cnt = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_cnt", 64'(wr_count), 64'd0);
        in_valid = 0;
        rst = 0;

        // add rd=3 rs=1 rt=2
        issue(5'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221803, 1);
        load(8'h00);
        // addi rt=5 rs=0, lw rt=4 rs=29 (rd non-zero must not leak)
        issue(5'd12, 5'd0, 5'd5, 5'd7, 16'h0010, 26'h0, 32'h4C050010, 1);
        issue(5'd17, 5'd29, 5'd4, 5'd7, 16'h0008, 26'h0, 32'h8FA40008, 1);
        // jal, jr with junk in unused fields
        issue(5'd21, 5'd9, 5'd9, 5'd9, 16'hFFFF, 26'h40, 32'hCC000040, 1);
        issue(5'd8, 5'd31, 5'd3, 5'd4, 16'h1234, 26'h3FFFFFF, 32'h03E00008, 1);
        issue(5'd18, 5'd9, 5'd8, 5'd1, 16'hFFFC, 26'h0, 32'hAD28FFFC, 1);
        issue(5'd19, 5'd1, 5'd2, 5'd0, 16'h0003, 26'h0, 32'hC0220003, 1);
        issue(5'd20, 5'd1, 5'd1, 5'd1, 16'h0, 26'h3FFFFFF, 32'hC7FFFFFF, 1);
        issue(5'd9, 5'd1, 5'd1, 5'd0, 16'hABCD, 26'h0, 32'h4021ABCD, 1);
        issue(5'd5, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0, 32'h03FFF805, 1);
        issue(5'd16, 5'd3, 5'd2, 5'd0, 16'h0001, 26'h0, 32'h5C620001, 1);
        // illegal mnemonics
        issue(5'd25, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 0);
        issue(5'd22, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h0, 0);

        // top-address write sets full and blocks further requests
        load(8'hFF);
        issue(5'd7, 5'd2, 5'd3, 5'd1, 16'h0, 26'h0, 32'h00430807, 1);
        chk("full_set", 64'(full), 64'd1);
        chk("full_addr_hold", 64'(imem_addr), 64'hFF);
        chk("full_cnt", 64'(wr_count), 64'd1);
        @(negedge clk);
        mnem = 5'd3; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("full_ready_low", 64'(in_ready), 64'd0);
        end
        in_valid = 0;
        load(8'h00);

        // reset during ENC aborts the pending write
        issue(5'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221803, 1);
        @(negedge clk);
        mnem = 5'd3; rs = 1; rt = 2; rd = 3; in_valid = 1;
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("arst_we", 64'(imem_we), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd0);
        chk("arst_addr", 64'(imem_addr), 64'd0);
        chk("arst_wdata", 64'(imem_wdata), 64'd0);
        chk("arst_full", 64'(full), 64'd0);
        chk("arst_err", 64'(err), 64'd0);
        chk("arst_cnt", 64'(wr_count), 64'd0);
        rst = 0;
        repeat (5) @(negedge clk);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
